// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with swap/bypass on simultaneous push+pop, top-of-stack peek,
// almost-full watermark and sticky overflow/underflow flags.
module lifo_stack #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 4,
  parameter int AF_MARGIN = 1,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [WIDTH-1:0] top,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(DEPTH - AF_MARGIN);

  // A fresh error in the same cycle as a clear takes priority.
  function automatic logic sticky_next(input logic q, input logic clr, input logic set);
    return (q & ~clr) | set;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             dv_q, dv_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic             is_empty, is_full;
  logic [CW-1:0]    cnt_m1;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic             wr_en;
  logic             ovf_set, udf_set;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);
  assign cnt_m1   = count_q - CW'(1);
  assign top_idx  = cnt_m1[AW-1:0];

  always_comb begin
    count_d    = count_q;
    data_out_d = data_out_q;
    dv_d       = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = count_q[AW-1:0];
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (is_full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (is_empty) begin
          udf_set = 1'b1;
        end else begin
          data_out_d = mem_q[top_idx];
          dv_d       = 1'b1;
          count_d    = cnt_m1;
        end
      end
      2'b11: begin
        dv_d = 1'b1;
        if (is_empty) begin
          data_out_d = data_in;
        end else begin
          // Swap: hand out the old top and overwrite it in place.
          data_out_d = mem_q[top_idx];
          wr_en      = 1'b1;
          wr_idx     = top_idx;
        end
      end
      default: ;
    endcase
    ovf_d = sticky_next(ovf_q, clr_err, ovf_set);
    udf_d = sticky_next(udf_q, clr_err, udf_set);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q    <= '0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      data_out_q <= data_out_d;
      dv_q       <= dv_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr_en) mem_q[wr_idx] <= data_in;
  end

  assign data_out    = data_out_q;
  assign data_valid  = dv_q;
  assign top         = is_empty ? '0 : mem_q[top_idx];
  assign count       = count_q;
  assign full        = is_full;
  assign empty       = is_empty;
  assign almost_full = (count_q >= AF_C);
  assign overflow    = ovf_q;
  assign underflow   = udf_q;

endmodule
